syscall_ctrl: RTL and testbench

Sequencing controller for SYSCALL in the CPU's execute stage. When the function decoder flags a syscall, this block decodes the service number in $v0 and acts on it:
- print-integer and print-hex: stalls the pipeline, hands $a0 to the display port over a valid/ready handshake, then releases the instruction.
- exit: freezes the CPU permanently.
- any other service: retires as a no-op with no stall.

---
 rtl/syscall_pkg.sv | 24 ++
 rtl/sat_counter.sv | 42 ++++
 rtl/syscall_ctrl.sv | 148 ++++++++++++++
 tb/tb_syscall_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// ---------------------------------------------------------------------------
// syscall_pkg
// Shared definitions for the SYSCALL sequencing controller: the controller
// state encoding and the service numbers decoded from $v0. Imported by the
// control unit and by its testbench so both agree on the service codes.
// No ports (package).
// ---------------------------------------------------------------------------
package syscall_pkg;

  // Controller states: waiting for a syscall, offering a print to the
  // display, retiring the syscall for one cycle, and the terminal halt.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Service numbers carried in $v0.
  localparam int SYS_PRINT_INT = 1;
  localparam int SYS_PRINT_HEX = 34;
  localparam int SYS_EXIT      = 10;

endpackage : syscall_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low clear
//   inc_i    in   count one event this cycle
//   count_o  out  current count (WIDTH bits)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step by one on an increment unless already at the ceiling,
  // so the value never wraps back to zero.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/syscall_ctrl.sv
// ---------------------------------------------------------------------------
// syscall_ctrl
// Sequences a SYSCALL in the execute stage. Print services (int / hex) stall
// the pipeline while $a0 is offered to the display over valid/ready, exit
// freezes the CPU until reset, and every other service retires as a no-op.
//
// Optional feature macro: SYSCALL_COUNT_EN
//   defined   -> sys_count counts completed print handshakes, saturating
//   undefined -> no counter flops, sys_count tied to zero
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   syscall_valid  in   valid SYSCALL instruction sitting in EX
//   v0             in   forwarded $v0 (service number)
//   a0             in   forwarded $a0 (value to print)
//   stall          out  hold PC and IF/ID/EX (combinational)
//   halt           out  CPU halted (registered)
//   disp_valid     out  display request (registered)
//   disp_data      out  value to display (registered)
//   disp_hex       out  1 = hex format, 0 = signed decimal (registered)
//   disp_ready     in   display sink accepts this cycle
//   sys_count      out  completed print handshakes, saturating
// ---------------------------------------------------------------------------
module syscall_ctrl
  import syscall_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              syscall_valid,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              stall,
  output logic              halt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_hex,
  input  logic              disp_ready,
  output logic [CNT_W-1:0]  sys_count
);

  state_e            state_q, state_d;
  logic              halt_q;
  logic              dispValid_q;
  logic [DATA_W-1:0] dispData_q;
  logic              dispHex_q;

  logic              isPrintInt;
  logic              isPrintHex;
  logic              isExit;
  logic              captureEn;

  // Service decode compares the whole register, so a value such as 0x101
  // does not alias onto print-int through its low bits.
  always_comb begin
    isPrintInt = (v0 == DATA_W'(SYS_PRINT_INT));
    isPrintHex = (v0 == DATA_W'(SYS_PRINT_HEX));
    isExit     = (v0 == DATA_W'(SYS_EXIT));
  end

  // Next-state and stall logic. The stall in IDLE is combinational so the
  // syscall is held in EX in the very cycle it is decoded. DONE drops stall
  // to let the syscall retire, and ignores syscall_valid because the
  // instruction still visible in EX is that same retiring syscall.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    captureEn = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (syscall_valid) begin
          if (isPrintInt || isPrintHex) begin
            stall     = 1'b1;
            captureEn = 1'b1;
            state_d   = ISSUE;
          end else if (isExit) begin
            stall   = 1'b1;
            state_d = HALT;
          end
        end
      end
      ISSUE: begin
        stall = 1'b1;
        if (disp_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      HALT: begin
        stall = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. disp_valid and halt are registered copies
  // of the next state, so they line up exactly with ISSUE and HALT. The
  // display payload is loaded only on entry to ISSUE, which keeps it stable
  // for the whole time the request is waiting on disp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      halt_q      <= 1'b0;
      dispValid_q <= 1'b0;
      dispData_q  <= '0;
      dispHex_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_q      <= (state_d == HALT);
      dispValid_q <= (state_d == ISSUE);
      if (captureEn) begin
        dispData_q <= a0;
        dispHex_q  <= isPrintHex;
      end
    end
  end

  assign halt       = halt_q;
  assign disp_valid = dispValid_q;
  assign disp_data  = dispData_q;
  assign disp_hex   = dispHex_q;

`ifdef SYSCALL_COUNT_EN
  logic countInc;

  // A print completes on the edge that closes the handshake in ISSUE.
  assign countInc = (state_q == ISSUE) && disp_ready;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_sat_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (countInc),
    .count_o (sys_count)
  );
`else
  assign sys_count = '0;
`endif

endmodule : syscall_ctrl

// File: tb/tb_syscall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_syscall_ctrl
// Self-checking bench for syscall_ctrl. The DUT is built with CNT_W = 2 so
// the completed-print counter reaches its ceiling within a few prints.
// Expected values come from the service rules: a print stalls for 2 cycles
// plus one per cycle the display holds off, shows $a0 once per offered
// cycle, and a completed print bumps a saturating count.
// ---------------------------------------------------------------------------
module tb_syscall_ctrl;
  import syscall_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              syscall_valid;
  logic [DATA_W-1:0] v0;
  logic [DATA_W-1:0] a0;
  logic              stall;
  logic              halt;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              disp_hex;
  logic              disp_ready;
  logic [CNT_W-1:0]  sys_count;

  int checks   = 0;
  int failures = 0;
  int printsDone = 0;

  // What one syscall looked like from outside, cycle by cycle condensed.
  typedef struct {
    int          stallCnt;
    int          firstStall;
    int          dvCnt;
    int          firstDv;
    logic [31:0] dvData;
    logic        dvHex;
    int          unstable;
    int          haltSeen;
  } obs_t;

  syscall_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .syscall_valid (syscall_valid),
    .v0            (v0),
    .a0            (a0),
    .stall         (stall),
    .halt          (halt),
    .disp_valid    (disp_valid),
    .disp_data     (disp_data),
    .disp_hex      (disp_hex),
    .disp_ready    (disp_ready),
    .sys_count     (sys_count)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something in the bench itself stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected counter value: completed prints, clipped at the ceiling, or
  // zero when the counter is compiled out.
  function automatic int expCount();
`ifdef SYSCALL_COUNT_EN
    return (printsDone > CNT_MAX) ? CNT_MAX : printsDone;
`else
    return 0;
`endif
  endfunction

  function automatic bit isPrintCode(input logic [31:0] v);
    return (v == 32'd1) || (v == 32'd34);
  endfunction

  // Drive all DUT inputs at once.
  task automatic applyStimulus(input logic sv, input logic [31:0] v,
                               input logic [31:0] a, input logic rdy);
    syscall_valid = sv;
    v0            = v;
    a0            = a;
    disp_ready    = rdy;
  endtask

  // Present one syscall and watch it for delay+3 cycles. Like a real
  // pipeline, the instruction stays in EX for one more cycle after every
  // stalled cycle. The display holds disp_ready low for 'delay' cycles of
  // an offered print. Called at posedge+1; returns at posedge+1.
  task automatic observeSyscall(input logic [31:0] v, input logic [31:0] a,
                                input int delay, output obs_t o);
    logic prevStall;
    int   dvSeen;
    o = '{default: 0};
    o.firstStall = -1;
    o.firstDv    = -1;
    prevStall = 1'b0;
    dvSeen    = 0;
    for (int n = 0; n < delay + 3; n++) begin
      applyStimulus((n == 0) || prevStall, v, a,
                    (n == 0) ? 1'($urandom_range(0, 1)) : 1'(dvSeen >= delay));
      @(negedge clk);
      prevStall = stall;
      if (stall === 1'b1) begin
        o.stallCnt++;
        if (o.firstStall < 0) o.firstStall = n;
      end
      if (halt !== 1'b0) o.haltSeen++;
      if (disp_valid === 1'b1) begin
        if (o.dvCnt == 0) begin
          o.firstDv = n;
          o.dvData  = disp_data;
          o.dvHex   = disp_hex;
        end else if (disp_data !== o.dvData || disp_hex !== o.dvHex) begin
          o.unstable++;
        end
        o.dvCnt++;
        dvSeen++;
      end
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  // Out of reset everything is quiet and the counter is zero.
  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (halt !== 1'b0) begin failures++; $display("[TB] FAIL reset_halt: got %b expected 0", halt); end
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dv: got %b expected 0", disp_valid); end
    checks++; if (disp_data !== '0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", disp_data); end
    checks++; if (disp_hex !== 1'b0) begin failures++; $display("[TB] FAIL reset_hex: got %b expected 0", disp_hex); end
    checks++; if (sys_count !== '0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", sys_count); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Print-int with the display already ready: two stall cycles, one offer.
  task automatic test_print_int();
    obs_t o;
    observeSyscall(32'd1, 32'hFFFF_FFFE, 0, o);
    printsDone++;
    checks++; if (o.stallCnt != 2) begin failures++; $display("[TB] FAIL pint_stall: got %0d expected 2", o.stallCnt); end
    checks++; if (o.firstStall != 0) begin failures++; $display("[TB] FAIL pint_first_stall: got %0d expected 0", o.firstStall); end
    checks++; if (o.dvCnt != 1) begin failures++; $display("[TB] FAIL pint_dv: got %0d expected 1", o.dvCnt); end
    checks++; if (o.firstDv != 1) begin failures++; $display("[TB] FAIL pint_first_dv: got %0d expected 1", o.firstDv); end
    checks++; if (o.dvData !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL pint_data: got %h expected fffffffe", o.dvData); end
    checks++; if (o.dvHex !== 1'b0) begin failures++; $display("[TB] FAIL pint_hex: got %b expected 0", o.dvHex); end
    checks++; if (int'(sys_count) != expCount()) begin failures++; $display("[TB] FAIL pint_count: got %0d expected %0d", sys_count, expCount()); end
  endtask

  // Print-hex with three cycles of backpressure.
  task automatic test_print_hex_backpressure();
    obs_t o;
    observeSyscall(32'd34, 32'h1234_ABCD, 3, o);
    printsDone++;
    checks++; if (o.stallCnt != 5) begin failures++; $display("[TB] FAIL phex_stall: got %0d expected 5", o.stallCnt); end
    checks++; if (o.dvCnt != 4) begin failures++; $display("[TB] FAIL phex_dv: got %0d expected 4", o.dvCnt); end
    checks++; if (o.unstable != 0) begin failures++; $display("[TB] FAIL phex_stable: got %0d changes expected 0", o.unstable); end
    checks++; if (o.dvData !== 32'h1234_ABCD) begin failures++; $display("[TB] FAIL phex_data: got %h expected 1234abcd", o.dvData); end
    checks++; if (o.dvHex !== 1'b1) begin failures++; $display("[TB] FAIL phex_hex: got %b expected 1", o.dvHex); end
    checks++; if (int'(sys_count) != expCount()) begin failures++; $display("[TB] FAIL phex_count: got %0d expected %0d", sys_count, expCount()); end
  endtask

  // Codes outside the service set, including ones whose low bits alias a
  // real service, must never stall or print.
  task automatic test_unknown();
    logic [31:0] codes [4];
    obs_t o;
    codes = '{32'd5, 32'h0000_0101, 32'h0001_0022, 32'h8000_000A};
    foreach (codes[i]) begin
      observeSyscall(codes[i], $urandom, $urandom_range(0, 2), o);
      checks++; if (o.stallCnt != 0) begin failures++; $display("[TB] FAIL unk_stall[%h]: got %0d expected 0", codes[i], o.stallCnt); end
      checks++; if (o.dvCnt != 0) begin failures++; $display("[TB] FAIL unk_dv[%h]: got %0d expected 0", codes[i], o.dvCnt); end
      checks++; if (o.haltSeen != 0) begin failures++; $display("[TB] FAIL unk_halt[%h]: got %0d expected 0", codes[i], o.haltSeen); end
    end
  endtask

  // Prints issued as soon as the previous one has retired.
  task automatic test_back_to_back();
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = $urandom;
      observeSyscall((i == 1) ? 32'd34 : 32'd1, a, 0, o);
      printsDone++;
      checks++; if (o.stallCnt != 2) begin failures++; $display("[TB] FAIL b2b_stall[%0d]: got %0d expected 2", i, o.stallCnt); end
      checks++; if (o.dvCnt != 1) begin failures++; $display("[TB] FAIL b2b_dv[%0d]: got %0d expected 1", i, o.dvCnt); end
      checks++; if (o.dvData !== a) begin failures++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, o.dvData, a); end
      checks++; if (o.dvHex !== (i == 1)) begin failures++; $display("[TB] FAIL b2b_hex[%0d]: got %b expected %b", i, o.dvHex, (i == 1)); end
    end
  endtask

  // Random mix of prints, no-ops and aliased codes with random backpressure.
  task automatic test_random_mix();
    obs_t o;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] v, a;
      int delay, expStall, expDv;
      case ($urandom_range(0, 4))
        0: v = 32'd1;
        1: v = 32'd34;
        2: begin v = $urandom; if (v == 32'd1 || v == 32'd10 || v == 32'd34) v = 32'd5; end
        3: v = 32'd34 | (32'd1 << $urandom_range(6, 31));
        default: begin v = $urandom_range(0, 40); if (v == 32'd1 || v == 32'd10 || v == 32'd34) v = 32'd0; end
      endcase
      a = $urandom;
      delay = $urandom_range(0, 3);
      expStall = isPrintCode(v) ? 2 + delay : 0;
      expDv    = isPrintCode(v) ? 1 + delay : 0;
      observeSyscall(v, a, delay, o);
      if (isPrintCode(v)) printsDone++;
      checks++; if (o.stallCnt != expStall) begin failures++; $display("[TB] FAIL rnd_stall[%0d v=%h]: got %0d expected %0d", i, v, o.stallCnt, expStall); end
      checks++; if (o.dvCnt != expDv) begin failures++; $display("[TB] FAIL rnd_dv[%0d v=%h]: got %0d expected %0d", i, v, o.dvCnt, expDv); end
      checks++; if (o.unstable != 0) begin failures++; $display("[TB] FAIL rnd_stable[%0d]: got %0d changes expected 0", i, o.unstable); end
      checks++; if (o.haltSeen != 0) begin failures++; $display("[TB] FAIL rnd_halt[%0d]: got %0d expected 0", i, o.haltSeen); end
      if (isPrintCode(v)) begin
        checks++; if (o.dvData !== a) begin failures++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", i, o.dvData, a); end
        checks++; if (o.dvHex !== (v == 32'd34)) begin failures++; $display("[TB] FAIL rnd_hex[%0d]: got %b expected %b", i, o.dvHex, (v == 32'd34)); end
      end
      checks++; if (int'(sys_count) != expCount()) begin failures++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, sys_count, expCount()); end
    end
  endtask

  // Reset arriving while a print waits on the display clears everything
  // at once, without waiting for a clock edge.
  task automatic test_reset_mid_issue();
    applyStimulus(1'b1, 32'd1, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1) begin failures++; $display("[TB] FAIL rmi_pre_dv: got %b expected 1", disp_valid); end
    #2;
    syscall_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    printsDone = 0;
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rmi_stall: got %b expected 0", stall); end
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmi_dv: got %b expected 0", disp_valid); end
    checks++; if (disp_data !== '0) begin failures++; $display("[TB] FAIL rmi_data: got %h expected 0", disp_data); end
    checks++; if (halt !== 1'b0) begin failures++; $display("[TB] FAIL rmi_halt: got %b expected 0", halt); end
    checks++; if (sys_count !== '0) begin failures++; $display("[TB] FAIL rmi_count: got %0d expected 0", sys_count); end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Five prints from a cleared counter: the count climbs then sticks.
  task automatic test_saturation();
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      observeSyscall(32'd1, $urandom, $urandom_range(0, 1), o);
      printsDone++;
      checks++; if (o.dvCnt == 0) begin failures++; $display("[TB] FAIL sat_dv[%0d]: got 0 offers expected at least 1", i); end
      checks++; if (int'(sys_count) != expCount()) begin failures++; $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", i, sys_count, expCount()); end
    end
  endtask

  // Exit freezes the CPU; later syscalls are not serviced. Reset recovers.
  task automatic test_exit();
    int stallLow, haltLow, dvHigh;
    stallLow = 0; haltLow = 0; dvHigh = 0;
    applyStimulus(1'b1, 32'd10, $urandom, 1'b1);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL exit_c0_stall: got %b expected 1", stall); end
    checks++; if (halt !== 1'b0) begin failures++; $display("[TB] FAIL exit_c0_halt: got %b expected 0", halt); end
    @(posedge clk);
    #1;
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(n >= 5, (n >= 5) ? 32'd1 : 32'd10, $urandom, 1'b1);
      @(negedge clk);
      if (stall !== 1'b1) stallLow++;
      if (halt !== 1'b1) haltLow++;
      if (disp_valid !== 1'b0) dvHigh++;
      @(posedge clk);
      #1;
    end
    checks++; if (stallLow != 0) begin failures++; $display("[TB] FAIL exit_stall: got %0d low cycles expected 0", stallLow); end
    checks++; if (haltLow != 0) begin failures++; $display("[TB] FAIL exit_halt: got %0d low cycles expected 0", haltLow); end
    checks++; if (dvHigh != 0) begin failures++; $display("[TB] FAIL exit_dv: got %0d offer cycles expected 0", dvHigh); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (halt !== 1'b0) begin failures++; $display("[TB] FAIL exit_reset_halt: got %b expected 0", halt); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL exit_reset_stall: got %b expected 0", stall); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_print_int();
    test_print_hex_backpressure();
    test_unknown();
    test_back_to_back();
    test_random_mix();
    test_reset_mid_issue();
    test_saturation();
    test_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_syscall_ctrl
